// File: rtl/date_pkg.sv
// Shared BCD calendar definitions: digit widths, month codes, reset defaults
// and the month-length sets used by the date counter and its month_len helper.
package date_pkg;

    localparam int DIGIT_W = 4;
    localparam int BCD_W   = 2 * DIGIT_W;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [BCD_W-1:0] {
        JAN = 8'h01, FEB = 8'h02, MAR = 8'h03, APR = 8'h04,
        MAY = 8'h05, JUN = 8'h06, JUL = 8'h07, AUG = 8'h08,
        SEP = 8'h09, OCT = 8'h10, NOV = 8'h11, DEC = 8'h12
    } month_e;

    localparam bcd_t RST_DAY   = 8'h01;
    localparam bcd_t RST_MONTH = 8'h01;
    localparam bcd_t FIRST_DAY = 8'h01;
    localparam bcd_t LAST_YEAR = 8'h99;
    localparam bcd_t LEN_31    = 8'h31;
    localparam bcd_t LEN_30    = 8'h30;
    localparam bcd_t LEN_29    = 8'h29;
    localparam bcd_t LEN_28    = 8'h28;
    // Returned for an illegal month code so that no day can validate against it.
    localparam bcd_t LEN_NONE  = 8'h00;

    function automatic logic is_31_month(input bcd_t m);
        case (m)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: is_31_month = 1'b1;
            default:                           is_31_month = 1'b0;
        endcase
    endfunction

    function automatic logic is_30_month(input bcd_t m);
        case (m)
            APR, JUN, SEP, NOV: is_30_month = 1'b1;
            default:            is_30_month = 1'b0;
        endcase
    endfunction

    // Divisibility by 4 of a two-digit BCD value, evaluated digit-wise.
    function automatic logic is_leap(input bcd_t y);
        logic [DIGIT_W-1:0] ones;
        ones = y[DIGIT_W-1:0];
        if (y[DIGIT_W] == 1'b0)
            is_leap = (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
        else
            is_leap = (ones == 4'd2) || (ones == 4'd6);
    endfunction

    function automatic logic bcd_ok(input bcd_t v);
        bcd_ok = (v[DIGIT_W-1:0] <= 4'd9) && (v[BCD_W-1:DIGIT_W] <= 4'd9);
    endfunction

    function automatic bcd_t bcd_inc(input bcd_t v);
        logic [DIGIT_W-1:0] ones;
        logic [DIGIT_W-1:0] tens;
        ones = v[DIGIT_W-1:0];
        tens = v[BCD_W-1:DIGIT_W];
        if (ones == 4'd9)
            bcd_inc = {tens + 4'd1, 4'd0};
        else
            bcd_inc = {tens, ones + 4'd1};
    endfunction

endpackage

// File: rtl/month_len.sv
// Combinational last-day lookup: BCD month and BCD year in, BCD last day out
// (LEN_NONE for a month code outside 01-12).
module month_len
    import date_pkg::*;
(
    input  logic [BCD_W-1:0] month,
    input  logic [BCD_W-1:0] year,
    output logic [BCD_W-1:0] last_day
);

    always_comb begin
        last_day = LEN_NONE;
        if (is_31_month(month))
            last_day = LEN_31;
        else if (is_30_month(month))
            last_day = LEN_30;
        else if (month == FEB)
            last_day = is_leap(year) ? LEN_29 : LEN_28;
    end

endmodule

// File: rtl/date_counter.sv
// BCD calendar date register (day/month/year, century 20xx) with day advance,
// validated atomic load, century-wrap and load-error pulses.
module date_counter
    import date_pkg::*;
#(
    parameter bcd_t RST_YEAR = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [BCD_W-1:0]   set_day,
    input  logic [BCD_W-1:0]   set_month,
    input  logic [BCD_W-1:0]   set_year,
    output logic [DIGIT_W-1:0] day0,
    output logic [DIGIT_W-1:0] day1,
    output logic [DIGIT_W-1:0] month0,
    output logic [DIGIT_W-1:0] month1,
    output logic [DIGIT_W-1:0] year0,
    output logic [DIGIT_W-1:0] year1,
    output logic               year_wrap,
    output logic               load_err
);

    bcd_t day_q;
    bcd_t month_q;
    bcd_t year_q;
    bcd_t run_last;
    bcd_t set_last;
    logic load_ok;

    month_len u_run_len (
        .month    (month_q),
        .year     (year_q),
        .last_day (run_last)
    );

    month_len u_set_len (
        .month    (set_month),
        .year     (set_year),
        .last_day (set_last)
    );

    // Legal BCD digits make a plain binary compare equal to a numeric compare.
    always_comb begin
        load_ok = bcd_ok(set_day) && bcd_ok(set_month) && bcd_ok(set_year)
                  && (set_last != LEN_NONE)
                  && (set_day != 8'h00)
                  && (set_day <= set_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day_q     <= RST_DAY;
            month_q   <= RST_MONTH;
            year_q    <= RST_YEAR;
            year_wrap <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            year_wrap <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    day_q   <= set_day;
                    month_q <= set_month;
                    year_q  <= set_year;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (en) begin
                if (day_q == run_last) begin
                    day_q <= FIRST_DAY;
                    if (month_q == DEC) begin
                        month_q <= JAN;
                        if (year_q == LAST_YEAR) begin
                            year_q    <= 8'h00;
                            year_wrap <= 1'b1;
                        end else begin
                            year_q <= bcd_inc(year_q);
                        end
                    end else begin
                        month_q <= bcd_inc(month_q);
                    end
                end else begin
                    day_q <= bcd_inc(day_q);
                end
            end
        end
    end

    assign day0   = day_q[DIGIT_W-1:0];
    assign day1   = day_q[BCD_W-1:DIGIT_W];
    assign month0 = month_q[DIGIT_W-1:0];
    assign month1 = month_q[BCD_W-1:DIGIT_W];
    assign year0  = year_q[DIGIT_W-1:0];
    assign year1  = year_q[BCD_W-1:DIGIT_W];

endmodule

// File: tb/tb_date_counter.sv
// Scoreboard bench for date_counter: the driver pushes hand-computed expected
// dates per cycle, a monitor pops and compares them after each clock edge.
module tb_date_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] set_day;
    logic [7:0] set_month;
    logic [7:0] set_year;
    logic [3:0] day0, day1, month0, month1, year0, year1;
    logic       year_wrap;
    logic       load_err;

    int tests;
    int fails;

    typedef struct {
        string      tag;
        logic [7:0] d;
        logic [7:0] m;
        logic [7:0] y;
        logic       w;
        logic       e;
    } exp_t;

    exp_t sb[$];

    date_counter #(.RST_YEAR(8'h24)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .set_day   (set_day),
        .set_month (set_month),
        .set_year  (set_year),
        .day0      (day0),
        .day1      (day1),
        .month0    (month0),
        .month1    (month1),
        .year0     (year0),
        .year1     (year1),
        .year_wrap (year_wrap),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [7:0] d, m, y,
                           input logic w, e);
        logic [7:0] gd, gm, gy;
        gd = {day1, day0};
        gm = {month1, month0};
        gy = {year1, year0};
        tests++;
        if (gd !== d || gm !== m || gy !== y || year_wrap !== w || load_err !== e) begin
            fails++;
            $display("FAIL %s: got %h/%h/%h wrap=%b err=%b, want %h/%h/%h wrap=%b err=%b",
                     tag, gd, gm, gy, year_wrap, load_err, d, m, y, w, e);
        end
    endtask

    // Monitor: every clock edge, compare against the entry pushed for that edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                compare(x.tag, x.d, x.m, x.y, x.w, x.e);
            end
        end
    end

    task automatic drive(input logic e, l, input logic [7:0] sd, sm, sy);
        @(negedge clk);
        en        = e;
        load      = l;
        set_day   = sd;
        set_month = sm;
        set_year  = sy;
    endtask

    task automatic expect_next(input string tag, input logic [7:0] d, m, y,
                               input logic w, e);
        exp_t x;
        x.tag = tag; x.d = d; x.m = m; x.y = y; x.w = w; x.e = e;
        sb.push_back(x);
    endtask

    task automatic do_load(input string tag, input logic [7:0] sd, sm, sy);
        drive(1'b0, 1'b1, sd, sm, sy);
        expect_next(tag, sd, sm, sy, 1'b0, 1'b0);
    endtask

    task automatic do_en(input string tag, input logic [7:0] d, m, y, input logic w);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        expect_next(tag, d, m, y, w, 1'b0);
    endtask

    task automatic do_idle(input string tag, input logic [7:0] d, m, y);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        expect_next(tag, d, m, y, 1'b0, 1'b0);
    endtask

    // Rejected load: state held (current date given), err pulse, then dropped.
    task automatic bad_load(input string tag, input logic [7:0] sd, sm, sy,
                            input logic [7:0] d, m, y);
        drive(1'b0, 1'b1, sd, sm, sy);
        expect_next(tag, d, m, y, 1'b0, 1'b1);
        do_idle({tag, "_drop"}, d, m, y);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0; en = 1'b0; load = 1'b0;
        set_day = 8'h00; set_month = 8'h00; set_year = 8'h00;

        #1 rst = 1'b1;
        #1 compare("reset_async", 8'h01, 8'h01, 8'h24, 1'b0, 1'b0);
        en = 1'b1; load = 1'b1; set_day = 8'h05; set_month = 8'h05; set_year = 8'h05;
        @(posedge clk); #2;
        compare("reset_ignores_inputs", 8'h01, 8'h01, 8'h24, 1'b0, 1'b0);
        @(negedge clk);
        en = 1'b0; load = 1'b0;
        rst = 1'b0;

        do_idle("hold_after_reset", 8'h01, 8'h01, 8'h24);

        do_load("load_30_04_23", 8'h30, 8'h04, 8'h23);
        do_en("apr_end", 8'h01, 8'h05, 8'h23, 1'b0);
        do_load("load_31_12_23", 8'h31, 8'h12, 8'h23);
        do_en("year_end", 8'h01, 8'h01, 8'h24, 1'b0);

        do_load("load_28_02_24", 8'h28, 8'h02, 8'h24);
        do_en("leap_feb28", 8'h29, 8'h02, 8'h24, 1'b0);
        do_en("leap_feb29", 8'h01, 8'h03, 8'h24, 1'b0);
        do_load("load_28_02_23", 8'h28, 8'h02, 8'h23);
        do_en("nonleap_feb28", 8'h01, 8'h03, 8'h23, 1'b0);
        do_load("load_28_02_00", 8'h28, 8'h02, 8'h00);
        do_en("leap_2000", 8'h29, 8'h02, 8'h00, 1'b0);

        do_load("load_31_12_99", 8'h31, 8'h12, 8'h99);
        do_en("century_wrap", 8'h01, 8'h01, 8'h00, 1'b1);
        do_idle("wrap_drop", 8'h01, 8'h01, 8'h00);

        do_load("load_09_01_24", 8'h09, 8'h01, 8'h24);
        do_en("carry_09", 8'h10, 8'h01, 8'h24, 1'b0);
        do_load("load_19_01_24", 8'h19, 8'h01, 8'h24);
        do_en("carry_19", 8'h20, 8'h01, 8'h24, 1'b0);
        do_load("load_29_01_24", 8'h29, 8'h01, 8'h24);
        do_en("carry_29", 8'h30, 8'h01, 8'h24, 1'b0);

        bad_load("bad_29_02_23", 8'h29, 8'h02, 8'h23, 8'h30, 8'h01, 8'h24);
        bad_load("bad_31_06_24", 8'h31, 8'h06, 8'h24, 8'h30, 8'h01, 8'h24);
        bad_load("bad_00_05_24", 8'h00, 8'h05, 8'h24, 8'h30, 8'h01, 8'h24);
        bad_load("bad_15_13_24", 8'h15, 8'h13, 8'h24, 8'h30, 8'h01, 8'h24);
        bad_load("bad_1A_05_24", 8'h1A, 8'h05, 8'h24, 8'h30, 8'h01, 8'h24);
        do_load("load_31_10_24", 8'h31, 8'h10, 8'h24);
        do_en("oct_end", 8'h01, 8'h11, 8'h24, 1'b0);

        drive(1'b1, 1'b1, 8'h10, 8'h10, 8'h10);
        expect_next("load_beats_en", 8'h10, 8'h10, 8'h10, 1'b0, 1'b0);
        do_idle("hold_idle", 8'h10, 8'h10, 8'h10);

        do_load("load_01_01_24", 8'h01, 8'h01, 8'h24);
        for (int i = 1; i <= 366; i++) begin
            drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
            if (i == 59)
                expect_next("run_59_days", 8'h29, 8'h02, 8'h24, 1'b0, 1'b0);
            else if (i == 366)
                expect_next("run_366_days", 8'h01, 8'h01, 8'h25, 1'b0, 1'b0);
        end
        do_idle("hold_after_run", 8'h01, 8'h01, 8'h25);

        do_load("load_15_06_30", 8'h15, 8'h06, 8'h30);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        #1 rst = 1'b1;
        #1 compare("reset_mid_op", 8'h01, 8'h01, 8'h24, 1'b0, 1'b0);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;
        do_en("resume_after_reset", 8'h02, 8'h01, 8'h24, 1'b0);
        do_idle("final_idle", 8'h02, 8'h01, 8'h24);

        repeat (3) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
